// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: opcode values and FSM
// state encoding.
package instr_sequencer_pkg;

    localparam int OPC_W = 3;

    typedef enum logic [OPC_W-1:0] {
        OP_MV   = 3'd0,
        OP_MVI  = 3'd1,
        OP_ADD  = 3'd2,
        OP_SUB  = 3'd3,
        OP_HALT = 3'd7
    } opcode_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_IMM_FETCH,
        S_IMM_LATCH,
        S_ISSUE,
        S_WAIT_DONE,
        S_HALTED,
        S_ERROR
    } state_t;

endpackage

// File: rtl/instr_sequencer_if.sv
// Bus bundle between the sequencer, its synchronous program ROM and the
// control unit it feeds. The master side is the sequencer.
interface instr_sequencer_if #(
    parameter int DATA_W = 9,
    parameter int ADDR_W = 5
) ();

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] IR;
    logic [DATA_W-1:0] DIN;
    logic              Run;
    logic              Done;

    modport master (
        output mem_addr, mem_rd, IR, DIN, Run,
        input  mem_data, Done
    );

    modport slave (
        input  mem_addr, mem_rd, IR, DIN, Run,
        output mem_data, Done
    );

endinterface

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches instruction words (plus the immediate for
// mvi) from a synchronous ROM, pulses Run, then holds IR/DIN until the
// control unit answers with Done. Stops on HALT, illegal opcode or timeout.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int DATA_W      = 9,
    parameter int ADDR_W      = 5,
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              Resetn,
    input  logic              start,
    instr_sequencer_if.master bus,
    output logic              busy,
    output logic              halted,
    output logic              error,
    output logic [ADDR_W-1:0] pc,
    output logic [CNT_W-1:0]  instr_count
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;

    logic [OPC_W-1:0]  rom_opc;
    logic [OPC_W-1:0]  ir_opc;

    assign rom_opc = bus.mem_data[DATA_W-1 -: OPC_W];
    assign ir_opc  = ir_q[DATA_W-1 -: OPC_W];

    // State and datapath registers; everything clears on the async reset.
    always_ff @(posedge clk or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            din_q   <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            din_q   <= din_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    // Next-state, datapath updates, ROM strobes and the Run pulse.
    always_comb begin
        // NOTE: every target gets a default first, so no branch leaves a
        // value unassigned and no latch is inferred.
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        din_d        = din_q;
        cnt_d        = cnt_q;
        tmo_d        = tmo_q;
        bus.mem_rd   = 1'b0;
        bus.mem_addr = pc_q;
        bus.Run      = 1'b0;

        case (state_q)
            S_IDLE, S_HALTED, S_ERROR: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                    cnt_d   = '0;
                end
            end
            S_FETCH: begin
                bus.mem_rd = 1'b1;
                state_d    = S_LATCH;
            end
            S_LATCH: begin
                // The word is kept even when it is not issued, for debug.
                ir_d = bus.mem_data;
                case (rom_opc)
                    OP_MVI:                state_d = S_IMM_FETCH;
                    OP_MV, OP_ADD, OP_SUB: state_d = S_ISSUE;
                    OP_HALT:               state_d = S_HALTED;
                    default:               state_d = S_ERROR;
                endcase
            end
            S_IMM_FETCH: begin
                bus.mem_rd   = 1'b1;
                bus.mem_addr = pc_q + ADDR_W'(1);
                state_d      = S_IMM_LATCH;
            end
            S_IMM_LATCH: begin
                din_d   = bus.mem_data;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                bus.Run = 1'b1;
                tmo_d   = '0;
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                // Done wins over an expiring timeout in the same cycle.
                if (bus.Done) begin
                    pc_d    = pc_q + ((ir_opc == OP_MVI) ? ADDR_W'(2) : ADDR_W'(1));
                    cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
                    state_d = S_FETCH;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                    if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                        state_d = S_ERROR;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy        = !(state_q inside {S_IDLE, S_HALTED, S_ERROR});
    assign halted      = (state_q == S_HALTED);
    assign error       = (state_q == S_ERROR);
    assign pc          = pc_q;
    assign instr_count = cnt_q;
    assign bus.IR      = ir_q;
    assign bus.DIN     = din_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: a behavioural sync ROM and control
// unit responder drive the DUT; each test queues the Run events it expects
// and a negedge monitor pops and checks them as Run pulses appear.
module tb_instr_sequencer;

    localparam int DATA_W      = 9;
    localparam int ADDR_W      = 5;
    localparam int TIMEOUT_CYC = 16;
    localparam int CNT_W       = 16;

    logic              clk = 1'b0;
    logic              Resetn;
    logic              start;
    logic              busy, halted, error;
    logic [ADDR_W-1:0] pc;
    logic [CNT_W-1:0]  instr_count;

    instr_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    instr_sequencer #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .Resetn(Resetn), .start(start), .bus(bus),
        .busy(busy), .halted(halted), .error(error),
        .pc(pc), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous program ROM: data valid the cycle after mem_rd.
    logic [DATA_W-1:0] rom [32];
    always @(posedge clk) if (bus.mem_rd) bus.mem_data <= rom[bus.mem_addr];

    // Control-unit responder: Done for one cycle, done_delay cycles after
    // the Run cycle; done_delay == 0 means never answer.
    int done_delay = 1;
    int cu_cnt;
    assign bus.Done = (cu_cnt == 1);
    always @(posedge clk or negedge Resetn) begin
        if (!Resetn)         cu_cnt <= 0;
        else if (bus.Run)    cu_cnt <= done_delay;
        else if (cu_cnt > 0) cu_cnt <= cu_cnt - 1;
    end

    typedef struct {
        logic [DATA_W-1:0] ir;
        logic [DATA_W-1:0] din;
        bit                chk_din;
        int                lat;      // edges after start, -1 = not checked
    } run_exp_t;

    run_exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int start_edge = 0;
    int run_cyc    = 0;
    int idle_cyc   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: checks each Run pulse against the queue and IR/DIN holding
    // while the instruction is outstanding.
    bit                in_wait = 0;
    run_exp_t          cur;
    always @(negedge clk) begin
        if (!Resetn) begin
            in_wait = 0;
        end else begin
            if (in_wait) begin
                check("ir_hold", bus.IR, cur.ir);
                if (cur.chk_din) check("din_hold", bus.DIN, cur.din);
                if (bus.Done) in_wait = 0;
            end
            if (bus.Run) begin
                run_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_run", bus.Run, 0);
                end else begin
                    cur = exp_q.pop_front();
                    check("run_ir", bus.IR, cur.ir);
                    if (cur.chk_din) check("run_din", bus.DIN, cur.din);
                    if (cur.lat >= 0) check("run_latency", cyc - start_edge, cur.lat);
                    in_wait = 1;
                end
            end
        end
    end

    task automatic push_run(input logic [DATA_W-1:0] ir, input logic [DATA_W-1:0] din,
                            input bit chk_din, input int lat);
        run_exp_t e;
        e.ir = ir; e.din = din; e.chk_din = chk_din; e.lat = lat;
        exp_q.push_back(e);
    endtask

    task automatic fill_rom(input logic [DATA_W-1:0] w);
        for (int i = 0; i < 32; i++) rom[i] = w;
    endtask

    task automatic do_start();
        @(negedge clk);
        start      = 1'b1;
        start_edge = cyc + 1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("idle_within_budget", busy, 0);
        idle_cyc = cyc;
    endtask

    task automatic check_runs_done(input string name);
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Resetn = 1'b0;
        start  = 1'b0;
        fill_rom(9'o700);
        #12;
        check("rst_ir", bus.IR, 0);
        check("rst_run", bus.Run, 0);
        check("rst_mem_rd", bus.mem_rd, 0);
        check("rst_busy", busy, 0);
        check("rst_pc", pc, 0);
        check("rst_count", instr_count, 0);
        @(negedge clk);
        Resetn = 1'b1;

        // 1: mv then HALT, Done one cycle after Run.
        fill_rom(9'o700);
        rom[0] = 9'o012;
        done_delay = 1;
        push_run(9'o012, '0, 0, 2);
        do_start();
        wait_idle(200);
        check("t1_halted", halted, 1);
        check("t1_error", error, 0);
        check("t1_pc", pc, 1);
        check("t1_count", instr_count, 1);
        check("t1_ir_halt", bus.IR, 9'o700);
        check_runs_done("t1_runs");

        // 2: mvi with immediate, Run 4 edges after start.
        fill_rom(9'o700);
        rom[0] = 9'o130;
        rom[1] = 9'h0A5;
        push_run(9'o130, 9'h0A5, 1, 4);
        do_start();
        wait_idle(200);
        check("t2_halted", halted, 1);
        check("t2_pc", pc, 2);
        check("t2_count", instr_count, 1);
        check("t2_din", bus.DIN, 9'h0A5);
        check_runs_done("t2_runs");

        // 3: add, sub, HALT with Done delayed 3 cycles.
        fill_rom(9'o700);
        rom[0] = 9'o212;
        rom[1] = 9'o321;
        done_delay = 3;
        push_run(9'o212, '0, 0, 2);
        push_run(9'o321, '0, 0, -1);
        do_start();
        wait_idle(200);
        check("t3_halted", halted, 1);
        check("t3_pc", pc, 2);
        check("t3_count", instr_count, 2);
        check_runs_done("t3_runs");

        // 4: no Done -> error after TIMEOUT_CYC WAIT_DONE cycles, then restart.
        fill_rom(9'o700);
        rom[0] = 9'o012;
        done_delay = 0;
        push_run(9'o012, '0, 0, 2);
        do_start();
        wait_idle(200);
        check("t4_error", error, 1);
        check("t4_halted", halted, 0);
        check("t4_pc", pc, 0);
        check("t4_count", instr_count, 0);
        // Run cycle, then TIMEOUT_CYC cycles of WAIT_DONE, then ERROR.
        check("t4_timeout_cycles", idle_cyc - run_cyc, TIMEOUT_CYC + 1);
        check_runs_done("t4_runs");
        done_delay = 1;
        push_run(9'o012, '0, 0, 2);
        do_start();
        check("t4_error_cleared", error, 0);
        wait_idle(200);
        check("t4r_halted", halted, 1);
        check("t4r_error", error, 0);
        check("t4r_count", instr_count, 1);
        check_runs_done("t4r_runs");

        // 5: illegal opcode at address 0.
        fill_rom(9'o700);
        rom[0] = 9'o400;
        do_start();
        wait_idle(200);
        check("t5_error", error, 1);
        check("t5_ir", bus.IR, 9'o400);
        check("t5_pc", pc, 0);
        check("t5_count", instr_count, 0);
        check_runs_done("t5_runs");

        // 6: mvi at the last address takes its immediate from address 0.
        fill_rom(9'o012);
        rom[0]  = 9'o130;
        rom[1]  = 9'o700;
        rom[31] = 9'o130;
        push_run(9'o130, 9'o700, 1, 4);
        for (int i = 2; i < 31; i++) push_run(9'o012, '0, 0, -1);
        push_run(9'o130, 9'o130, 1, -1);
        do_start();
        wait_idle(2000);
        check("t6_halted", halted, 1);
        check("t6_pc", pc, 1);
        check("t6_count", instr_count, 31);
        check_runs_done("t6_runs");

        // 7: async reset while waiting for Done, then a clean restart.
        fill_rom(9'o700);
        rom[0] = 9'o130;
        rom[1] = 9'h155;
        rom[2] = 9'o212;
        done_delay = 1;
        push_run(9'o130, 9'h155, 1, 4);
        push_run(9'o212, '0, 0, -1);
        do_start();
        for (int n = 0; n < 100 && instr_count != 1; n++) @(negedge clk);
        done_delay = 0;
        repeat (5) @(negedge clk);
        check("t7_pre_busy", busy, 1);
        check("t7_pre_ir", bus.IR, 9'o212);
        check("t7_pre_pc", pc, 2);
        #2;
        Resetn = 1'b0;
        #1;
        check("t7_rst_ir", bus.IR, 0);
        check("t7_rst_din", bus.DIN, 0);
        check("t7_rst_run", bus.Run, 0);
        check("t7_rst_mem_rd", bus.mem_rd, 0);
        check("t7_rst_mem_addr", bus.mem_addr, 0);
        check("t7_rst_busy", busy, 0);
        check("t7_rst_halted", halted, 0);
        check("t7_rst_error", error, 0);
        check("t7_rst_pc", pc, 0);
        check("t7_rst_count", instr_count, 0);
        check_runs_done("t7_runs");
        @(negedge clk);
        #2;
        Resetn = 1'b1;
        done_delay = 1;
        rom[0] = 9'o012;
        rom[1] = 9'o700;
        push_run(9'o012, '0, 0, 2);
        do_start();
        wait_idle(200);
        check("t7r_halted", halted, 1);
        check("t7r_pc", pc, 1);
        check("t7r_count", instr_count, 1);
        check_runs_done("t7r_runs");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Instruction-issuing initiator that drives the simple processor's control unit.
- Fetches 9-bit instruction words from a synchronous program ROM and presents each one on IR.
- For mvi, fetches the following word as the immediate and presents it on DIN.
- Pulses Run, then holds IR/DIN stable until the control unit answers with Done. Repeats until a HALT word, an illegal opcode, or a Done timeout.

Parameters:
- DATA_W, 9, instruction/immediate width (opcode IR[8:6], op1 IR[5:3], op2 IR[2:0]).
- ADDR_W, 5, program ROM address width; the PC wraps modulo 2^ADDR_W.
- TIMEOUT_CYC, 16, maximum cycles spent in WAIT_DONE before flagging an error.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- Resetn  input  1  asynchronous, active-low reset.
- start  input  1  sampled high in IDLE/HALTED/ERROR: restart from address 0; ignored otherwise.
- mem_addr  output  ADDR_W  ROM read address.
- mem_rd  output  1  ROM read strobe; mem_data is valid the cycle after.
- mem_data  input  DATA_W  ROM read data.
- IR  output  DATA_W  instruction word to the control unit.
- DIN  output  DATA_W  immediate operand for mvi.
- Run  output  1  one-cycle pulse requesting execution of IR.
- Done  input  1  control unit completion indication.
- busy  output  1  high in every state except IDLE, HALTED and ERROR.
- halted  output  1  high in HALTED.
- error  output  1  high in ERROR.
- pc  output  ADDR_W  address of the current instruction.
- instr_count  output  CNT_W  instructions retired since the last start; saturates at all-ones.

Behaviour:
- Reset (async, any state, including mid-instruction):
  - State is IDLE.
  - pc, IR, DIN, mem_addr, instr_count and the timeout counter are 0.
  - Run, mem_rd, busy, halted and error are 0.
- Opcodes:
  - 0 mv, 1 mvi, 2 add, 3 sub are issued.
  - 7 is HALT: not issued, go to HALTED.
  - 4, 5 and 6 are illegal: not issued, go to ERROR.
- IDLE: on start go to FETCH with pc=0 and instr_count=0.
- FETCH: mem_rd=1, mem_addr=pc. Next state is LATCH.
- LATCH:
  - IR <= mem_data.
  - If opcode is 1, go to IMM_FETCH.
  - If opcode is 0 to 3, go to ISSUE.
  - If opcode is 7, go to HALTED.
  - Otherwise go to ERROR.
  - IR keeps the offending word for debug.
- IMM_FETCH: mem_rd=1, mem_addr=pc+1 (mod 2^ADDR_W). Next state is IMM_LATCH.
- IMM_LATCH: DIN <= mem_data. Next state is ISSUE.
- ISSUE: Run=1 for exactly this one cycle. Clear the timeout counter. Next state is WAIT_DONE.
- WAIT_DONE:
  - IR and DIN are held constant.
  - On Done=1:
    - pc += 1 (mv/add/sub) or 2 (mvi), wrapping.
    - instr_count += 1.
    - Go to FETCH.
  - Else increment the timeout counter. When it reaches TIMEOUT_CYC, go to ERROR.
- Done is ignored in every state other than WAIT_DONE.
- Latency from the edge that samples start:
  - Non-mvi: Run is high in the cycle beginning 2 edges later.
  - mvi: Run is high in the cycle beginning 4 edges later.
  - Next fetch: mem_rd rises the cycle after Done is sampled.
- HALTED and ERROR: outputs hold their values and pc points at the offending word. start restarts from 0, clears the flag and clears instr_count.
- Wrap: mvi at the last address takes its immediate from address 0, and pc then becomes 1.
- Simultaneous events:
  - start while busy is ignored.
  - Done arriving in the same cycle the timeout would expire counts as success.

Decomposition:
- Shared package:
  - Opcode constants MV=0, MVI=1, ADD=2, SUB=3, HALT=7.
  - State encoding for IDLE, FETCH, LATCH, IMM_FETCH, IMM_LATCH, ISSUE, WAIT_DONE, HALTED, ERROR.
- No sub-module. The timeout counter and the FSM sit in one block.
- The bench uses a behavioural sync ROM model and a behavioural control-unit responder.

Test Plan:
- ROM {0:mv R1,R2=9'o012, 1:HALT=9'o700}, responder raises Done 1 cycle after Run, start pulse:
  - IR=9'o012 and Run pulses once, 2 edges after start.
  - pc then reads 1, and halted=1 with instr_count=1.
- ROM {0:mvi R3=9'o130, 1:9'h0A5, 2:HALT}:
  - DIN=9'h0A5 before Run rises (Run at edge 4).
  - After Done, pc jumps to 2; ends halted with instr_count=1.
- add then sub then HALT, Done delayed 3 cycles each:
  - IR stays constant throughout each wait; exactly two Run pulses.
  - instr_count=2, pc=2.
- Responder never raises Done: error=1 exactly TIMEOUT_CYC cycles after the ISSUE cycle; pc=0. A later start clears error and restarts.
- Word 9'o400 at address 0: error=1, no Run pulse, IR=9'o400.
- Resetn low while in WAIT_DONE: all outputs 0 immediately (async). Next start refetches address 0.
